// File: rtl/cti_pkg.sv
// Shared types and constants for the SPARC control-transfer redirect path:
// CTI kinds, Bicc condition codes, PC mux selects and the redirect FSM states.
package cti_pkg;

  typedef enum logic [1:0] {
    CT_BICC = 2'b00,
    CT_CALL = 2'b01,
    CT_JMPL = 2'b10,
    CT_RSVD = 2'b11
  } ct_type_t;

  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;

  localparam logic [1:0] PC_SEL_NPC = 2'b00;
  localparam logic [1:0] PC_SEL_TA  = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REDIRECT = 2'b01,
    ST_SQUASH   = 2'b10
  } state_t;

endpackage

// File: rtl/icc_cond_eval.sv
// Combinational SPARC integer condition evaluator: {cond, icc} -> taken.
// Shared by the branch redirect controller and the Ticc trap logic.
module icc_cond_eval
  import cti_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] icc,
  output logic       taken
);

  logic n, z, v, c;
  assign {n, z, v, c} = icc;

  always_comb begin
    // NOTE: default assignment first so every path drives taken; no latch.
    taken = 1'b0;
    case (cond)
      COND_BN:   taken = 1'b0;
      COND_BE:   taken = z;
      COND_BLE:  taken = z | (n ^ v);
      COND_BL:   taken = n ^ v;
      COND_BLEU: taken = c | z;
      COND_BCS:  taken = c;
      COND_BNEG: taken = n;
      COND_BVS:  taken = v;
      COND_BA:   taken = 1'b1;
      COND_BNE:  taken = ~z;
      COND_BG:   taken = ~(z | (n ^ v));
      COND_BGE:  taken = ~(n ^ v);
      COND_BGU:  taken = ~(c | z);
      COND_BCC:  taken = ~c;
      COND_BPOS: taken = ~n;
      COND_BVC:  taken = ~v;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cti_redirect_ctrl.sv
// Bicc/CALL/JMPL redirect controller driving the PC/nPC register mux, TA and LE.
// Optional branch statistics counters are enabled with `define CTI_STATS_EN.
module cti_redirect_ctrl
  import cti_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ct_valid,
  input  logic [1:0]       ct_type,
  input  logic [3:0]       cond,
  input  logic             annul,
  input  logic [3:0]       icc,
  input  logic [WIDTH-1:0] target_in,
  input  logic [WIDTH-1:0] jmpl_addr,
  output logic [1:0]       pc_sel,
  output logic [WIDTH-1:0] ta,
  output logic             pc_le,
  output logic             squash,
  output logic             misalign
`ifdef CTI_STATS_EN
  ,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      untaken_cnt
`endif
);

  state_t           state, state_nxt;
  logic [1:0]       pc_sel_nxt;
  logic [WIDTH-1:0] ta_nxt;
  logic             squash_nxt, misalign_nxt;
  logic             bicc_taken, accept;
  ct_type_t         kind;

  icc_cond_eval u_cond (
    .cond  (cond),
    .icc   (icc),
    .taken (bicc_taken)
  );

  assign kind   = ct_type_t'(ct_type);
  // The instruction seen while in SQUASH is the annulled delay slot itself.
  assign accept = ct_valid && (state != ST_SQUASH);
  assign pc_le  = ~stall & ~reset;

  always_comb begin
    state_nxt    = ST_IDLE;
    pc_sel_nxt   = PC_SEL_NPC;
    ta_nxt       = ta;
    squash_nxt   = 1'b0;
    misalign_nxt = 1'b0;
    if (accept) begin
      case (kind)
        CT_BICC: begin
          if (bicc_taken) begin
            state_nxt  = ST_REDIRECT;
            pc_sel_nxt = PC_SEL_TA;
            ta_nxt     = target_in;
            squash_nxt = (cond == COND_BA) && annul;
          end else if (annul) begin
            state_nxt  = ST_SQUASH;
            squash_nxt = 1'b1;
          end
        end
        CT_CALL: begin
          state_nxt  = ST_REDIRECT;
          pc_sel_nxt = PC_SEL_TA;
          ta_nxt     = target_in;
        end
        CT_JMPL: begin
          if (jmpl_addr[1:0] != 2'b00) begin
            misalign_nxt = 1'b1;
          end else begin
            state_nxt  = ST_REDIRECT;
            pc_sel_nxt = PC_SEL_ALU;
            ta_nxt     = jmpl_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc_sel   <= PC_SEL_NPC;
      ta       <= '0;
      squash   <= 1'b0;
      misalign <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      pc_sel   <= pc_sel_nxt;
      ta       <= ta_nxt;
      squash   <= squash_nxt;
      misalign <= misalign_nxt;
    end
  end

`ifdef CTI_STATS_EN
  logic count_taken, count_untaken;

  // Misaligned JMPL still counts as a taken transfer.
  assign count_taken   = accept && ((kind == CT_BICC && bicc_taken) ||
                                    kind == CT_CALL || kind == CT_JMPL);
  assign count_untaken = accept && kind == CT_BICC && !bicc_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt   <= '0;
      untaken_cnt <= '0;
    end else if (!stall) begin
      if (count_taken && taken_cnt != '1)
        taken_cnt <= taken_cnt + 32'd1;
      if (count_untaken && untaken_cnt != '1)
        untaken_cnt <= untaken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cti_redirect_ctrl.sv
// Self-checking bench for cti_redirect_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level model.
module tb_cti_redirect_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset, stall, ct_valid, annul;
  logic [1:0]       ct_type;
  logic [3:0]       cond, icc;
  logic [WIDTH-1:0] target_in, jmpl_addr;
  logic [1:0]       pc_sel;
  logic [WIDTH-1:0] ta;
  logic             pc_le, squash, misalign;
`ifdef CTI_STATS_EN
  logic [31:0]      taken_cnt, untaken_cnt;
`endif

  cti_redirect_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .ct_valid   (ct_valid),
    .ct_type    (ct_type),
    .cond       (cond),
    .annul      (annul),
    .icc        (icc),
    .target_in  (target_in),
    .jmpl_addr  (jmpl_addr),
    .pc_sel     (pc_sel),
    .ta         (ta),
    .pc_le      (pc_le),
    .squash     (squash),
    .misalign   (misalign)
`ifdef CTI_STATS_EN
    ,
    .taken_cnt  (taken_cnt),
    .untaken_cnt(untaken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bicc truth table written out row by row from the architecture manual.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'b1000: return 1'b1;
      4'b0000: return 1'b0;
      4'b1001: return !z;
      4'b0001: return z;
      4'b1010: return !(z || (n != v));
      4'b0010: return z || (n != v);
      4'b1011: return n == v;
      4'b0011: return n != v;
      4'b1100: return !(cy || z);
      4'b0100: return cy || z;
      4'b1101: return !cy;
      4'b0101: return cy;
      4'b1110: return !n;
      4'b0110: return n;
      4'b1111: return !v;
      default: return v;
    endcase
  endfunction

  // Expected visible outputs after an unstalled edge, plus bookkeeping flags.
  typedef struct packed {
    logic [1:0]  pc_sel;
    logic [31:0] ta;
    logic        sq;
    logic        mis;
    logic        in_slot;
    logic        tk;
    logic        ut;
  } exp_t;

  function automatic exp_t next_exp(input exp_t cur, input logic v, input logic [1:0] ty,
                                    input logic [3:0] c, input logic an, input logic [3:0] f,
                                    input logic [31:0] tgt, input logic [31:0] ja);
    exp_t r;
    r = cur;
    r.pc_sel = 2'd0; r.sq = 1'b0; r.mis = 1'b0; r.in_slot = 1'b0; r.tk = 1'b0; r.ut = 1'b0;
    if (v && !cur.in_slot) begin
      if (ty == 2'd0) begin
        if (cond_holds(c, f)) begin
          r.pc_sel = 2'd1; r.ta = tgt; r.sq = (c == 4'b1000) && an; r.tk = 1'b1;
        end else begin
          r.ut = 1'b1;
          if (an) begin r.sq = 1'b1; r.in_slot = 1'b1; end
        end
      end else if (ty == 2'd1) begin
        r.pc_sel = 2'd1; r.ta = tgt; r.tk = 1'b1;
      end else if (ty == 2'd2) begin
        r.tk = 1'b1;
        if (ja[1:0] != 2'b00) r.mis = 1'b1;
        else begin r.pc_sel = 2'd2; r.ta = ja; end
      end
    end
    return r;
  endfunction

  exp_t        m, nx;
  logic [31:0] m_taken, m_untaken;
  bit          m_live = 1'b0;

  always_comb nx = next_exp(m, ct_valid, ct_type, cond, annul, icc, target_in, jmpl_addr);

  always @(posedge clk) begin
    if (reset) begin
      m         <= '0;
      m_taken   <= '0;
      m_untaken <= '0;
      m_live    <= 1'b1;
    end else if (!stall) begin
      m         <= nx;
      m_taken   <= (m_taken == 32'hFFFF_FFFF) ? m_taken : m_taken + 32'(nx.tk);
      m_untaken <= (m_untaken == 32'hFFFF_FFFF) ? m_untaken : m_untaken + 32'(nx.ut);
    end
  end

  always @(negedge clk) begin
    check("pc_le", 32'(pc_le), 32'(!stall && !reset));
    if (m_live) begin
      check("pc_sel", 32'(pc_sel), 32'(m.pc_sel));
      check("ta", ta, m.ta);
      check("squash", 32'(squash), 32'(m.sq));
      check("misalign", 32'(misalign), 32'(m.mis));
`ifdef CTI_STATS_EN
      check("taken_cnt", taken_cnt, m_taken);
      check("untaken_cnt", untaken_cnt, m_untaken);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cti(input logic [1:0] ty, input logic [3:0] c, input logic an,
                         input logic [3:0] f, input logic [31:0] tgt, input logic [31:0] ja);
    ct_valid = 1'b1; ct_type = ty; cond = c; annul = an; icc = f;
    target_in = tgt; jmpl_addr = ja;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; ct_valid = 1'b0; ct_type = 2'd0; cond = 4'd0;
    annul = 1'b0; icc = 4'd0; target_in = '0; jmpl_addr = '0;

    cyc();
    check("rst_pc_le_0", 32'(pc_le), 0);
    cyc();
    check("rst_pc_le_1", 32'(pc_le), 0);
    check("rst_pc_sel", 32'(pc_sel), 0);
    check("rst_ta", ta, 0);
    check("rst_squash", 32'(squash), 0);
    reset = 1'b0;
    #1;
    check("post_rst_pc_le", 32'(pc_le), 1);

    // BNE with Z=0 is taken
    set_cti(2'b00, 4'b1001, 1'b0, 4'b0000, 32'h40, 32'h0);
    cyc(); ct_valid = 1'b0;
    check("bne_pc_sel", 32'(pc_sel), 1);
    check("bne_ta", ta, 32'h40);
    check("bne_squash", 32'(squash), 0);
    cyc();
    check("bne_done", 32'(pc_sel), 0);

    // BE with Z=0 and annul: squash the slot, ignore the slot's CTI
    set_cti(2'b00, 4'b0001, 1'b1, 4'b0000, 32'h44, 32'h0);
    cyc();
    check("be_an_pc_sel", 32'(pc_sel), 0);
    check("be_an_squash", 32'(squash), 1);
    set_cti(2'b01, 4'b0000, 1'b0, 4'b0000, 32'h80, 32'h0);
    cyc(); ct_valid = 1'b0;
    check("slot_ignored_pc_sel", 32'(pc_sel), 0);
    check("slot_ignored_squash", 32'(squash), 0);

    // BA with annul redirects and squashes
    set_cti(2'b00, 4'b1000, 1'b1, 4'b1111, 32'h100, 32'h0);
    cyc(); ct_valid = 1'b0;
    check("ba_an_pc_sel", 32'(pc_sel), 1);
    check("ba_an_ta", ta, 32'h100);
    check("ba_an_squash", 32'(squash), 1);
    cyc();
    check("ba_an_done", 32'(squash), 0);

    // JMPL misaligned, then aligned
    set_cti(2'b10, 4'b0000, 1'b0, 4'b0000, 32'h0, 32'h202);
    cyc(); ct_valid = 1'b0;
    check("jmpl_mis", 32'(misalign), 1);
    check("jmpl_mis_pc_sel", 32'(pc_sel), 0);
    cyc();
    check("jmpl_mis_pulse", 32'(misalign), 0);
    set_cti(2'b10, 4'b0000, 1'b0, 4'b0000, 32'h0, 32'h200);
    cyc(); ct_valid = 1'b0;
    check("jmpl_pc_sel", 32'(pc_sel), 2);
    check("jmpl_ta", ta, 32'h200);
    cyc();

    // DCTI couple: CALL followed directly by JMPL
    set_cti(2'b01, 4'b0000, 1'b0, 4'b0000, 32'h500, 32'h0);
    cyc();
    check("dcti_call", ta, 32'h500);
    set_cti(2'b10, 4'b0000, 1'b0, 4'b0000, 32'h0, 32'h600);
    cyc(); ct_valid = 1'b0;
    check("dcti_jmpl_pc_sel", 32'(pc_sel), 2);
    check("dcti_jmpl_ta", ta, 32'h600);
    cyc();

    // CALL held by a 3-cycle stall
    set_cti(2'b01, 4'b0000, 1'b0, 4'b0000, 32'h300, 32'h0);
    cyc(); ct_valid = 1'b0; stall = 1'b1;
    check("call_pc_sel", 32'(pc_sel), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_hold_pc_sel", 32'(pc_sel), 1);
      check("stall_hold_pc_le", 32'(pc_le), 0);
    end
    stall = 1'b0;
    #1;
    check("unstalled_pc_sel", 32'(pc_sel), 1);
    check("unstalled_pc_le", 32'(pc_le), 1);
    cyc();
    check("call_consumed", 32'(pc_sel), 0);

    // Reset during a stalled redirect discards it
    set_cti(2'b01, 4'b0000, 1'b0, 4'b0000, 32'h340, 32'h0);
    cyc(); ct_valid = 1'b0; stall = 1'b1;
    cyc();
    check("hold_before_rst", 32'(pc_sel), 1);
    reset = 1'b1;
    cyc();
    check("midrst_pc_sel", 32'(pc_sel), 0);
    check("midrst_ta", ta, 0);
    check("midrst_squash", 32'(squash), 0);
    check("midrst_pc_le", 32'(pc_le), 0);
    reset = 1'b0; stall = 1'b0;
    cyc();

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) < 2);
      stall     = ($urandom_range(0, 99) < 20);
      ct_valid  = ($urandom_range(0, 99) < 70);
      ct_type   = 2'($urandom_range(0, 3));
      cond      = 4'($urandom);
      annul     = 1'($urandom);
      icc       = 4'($urandom);
      target_in = $urandom;
      jmpl_addr = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      cyc();
    end

    reset = 1'b0; stall = 1'b0; ct_valid = 1'b0;
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
